// File: rtl/count_enable_ctrl.sv
// Run/stop and clear front end for the 4-bit counter: synchronizes and debounces two
// buttons, toggles a STOP/RUN state and emits a prescaled one-cycle enable tick.
module count_enable_ctrl #(
    parameter int PRESCALE = 10,
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_clr,
    output logic enable,
    output logic clr,
    output logic running
);

    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int NBTN = 2;
    localparam int BTN_RUN = 0;
    localparam int BTN_CLR = 1;

    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    D_LAST = 8'(DEBOUNCE - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [NBTN-1:0] w_btn_raw;
    logic [NBTN-1:0] w_rise;

    assign w_btn_raw = {btn_clr, btn_run};

    // Per button: 2-flop synchronizer, then a counter that must see DEBOUNCE
    // consecutive disagreeing samples before the debounced level follows.
    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            logic       r_s1;
            logic       r_s2;
            logic       r_deb;
            logic [7:0] r_dcnt;
            logic       w_mismatch;
            logic       w_settled;

            assign w_mismatch = r_s2 ^ r_deb;
            assign w_settled  = w_mismatch && (r_dcnt == D_LAST);
            assign w_rise[gi] = w_settled && r_s2;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_deb  <= 1'b0;
                    r_dcnt <= '0;
                end else begin
                    r_s1 <= w_btn_raw[gi];
                    r_s2 <= r_s1;
                    if (!w_mismatch) begin
                        r_dcnt <= '0;
                    end else if (w_settled) begin
                        r_deb  <= r_s2;
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 8'd1;
                    end
                end
            end
        end
    endgenerate

    logic w_run_evt;
    logic w_clr_evt;

    assign w_run_evt = w_rise[BTN_RUN];
    assign w_clr_evt = w_rise[BTN_CLR];

    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_run_evt) begin
            w_state_next = (r_state == ST_STOP) ? ST_RUN : ST_STOP;
        end
    end

    logic [PW-1:0] r_p;
    logic [PW-1:0] w_p_next;
    logic          r_enable;
    logic          w_enable_next;
    logic          r_clr;
    logic          r_running;
    logic          w_running_next;
    logic          w_toggle;
    logic          w_hold_zero;

    // A clear or a state change restarts the prescale period and suppresses
    // any tick that would have landed on the same edge.
    always_comb begin
        w_toggle       = (w_state_next != r_state);
        w_hold_zero    = (r_state == ST_STOP) || w_toggle || w_clr_evt;
        w_running_next = (w_state_next == ST_RUN);
        w_p_next       = '0;
        w_enable_next  = 1'b0;
        if (!w_hold_zero) begin
            if (r_p == P_LAST) begin
                w_p_next      = '0;
                w_enable_next = 1'b1;
            end else begin
                w_p_next      = r_p + PW'(1);
                w_enable_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p       <= '0;
            r_enable  <= 1'b0;
            r_clr     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_p       <= w_p_next;
            r_enable  <= w_enable_next;
            r_clr     <= w_clr_evt;
            r_running <= w_running_next;
        end
    end

    assign enable  = r_enable;
    assign clr     = r_clr;
    assign running = r_running;

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed event edges per output channel,
// a negedge monitor pops and compares whenever an output pulses or running changes.
module tb_count_enable_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic btn_run, btn_clr, btn1_run, btn1_clr;
    logic enable, clr, running;
    logic enable1, clr1, running1;

    count_enable_ctrl #(.PRESCALE(10), .DEBOUNCE(4)) u_dut (
        .clk(clk), .reset(reset), .btn_run(btn_run), .btn_clr(btn_clr),
        .enable(enable), .clr(clr), .running(running)
    );

    count_enable_ctrl #(.PRESCALE(1), .DEBOUNCE(4)) u_dut1 (
        .clk(clk), .reset(reset), .btn_run(btn1_run), .btn_clr(btn1_clr),
        .enable(enable1), .clr(clr1), .running(running1)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int    checks = 0;
    int    errors = 0;
    bit    done   = 1'b0;
    logic  prev_run, prev_run1;
    int    exp_q[6][$];
    string chan_name[6] = '{"enable", "clr", "running", "enable1", "running1", "clr1"};

    // Entries encode edge*2 + value; channels 0..5 as named above.
    task automatic expect_evt(input int ch, input int edge_no, input int val);
        exp_q[ch].push_back(edge_no * 2 + val);
    endtask

    task automatic check_chan(input int ch, input bit fired, input int val);
        int front;
        while (exp_q[ch].size() > 0 && (exp_q[ch][0] >>> 1) < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL %s missed: got no event, required value %0d at edge %0d",
                     chan_name[ch], exp_q[ch][0] & 1, exp_q[ch][0] >>> 1);
            void'(exp_q[ch].pop_front());
        end
        if (fired) begin
            checks++;
            if (exp_q[ch].size() == 0) begin
                errors++;
                $display("FAIL %s unexpected: got value %0d at edge %0d, required no event",
                         chan_name[ch], val, edge_cnt);
            end else begin
                front = exp_q[ch][0];
                if ((front >>> 1) != edge_cnt) begin
                    errors++;
                    $display("FAIL %s early: got value %0d at edge %0d, required next at edge %0d",
                             chan_name[ch], val, edge_cnt, front >>> 1);
                end else begin
                    void'(exp_q[ch].pop_front());
                    if ((front & 1) != val) begin
                        errors++;
                        $display("FAIL %s value: got %0d at edge %0d, required %0d",
                                 chan_name[ch], val, edge_cnt, front & 1);
                    end else begin
                        $display("ok %s value %0d at edge %0d", chan_name[ch], val, edge_cnt);
                    end
                end
            end
        end
    endtask

    task automatic check_val(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b at time %0t", name, got, req, $time);
        end else begin
            $display("ok %s = %b", name, got);
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            prev_run  <= running;
            prev_run1 <= running1;
        end else if (!done) begin
            check_chan(0, enable === 1'b1, 1);
            check_chan(1, clr === 1'b1, 1);
            check_chan(2, running !== prev_run, int'(running));
            check_chan(3, enable1 === 1'b1, 1);
            check_chan(4, running1 !== prev_run1, int'(running1));
            check_chan(5, clr1 === 1'b1, 1);
            prev_run  <= running;
            prev_run1 <= running1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int k, k2, k3, k4, k5, k6, k7;

    initial begin
        reset = 1'b0;
        btn_run = 1'b0; btn_clr = 1'b0; btn1_run = 1'b0; btn1_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_enable", enable, 1'b0);
        check_val("reset_clr", clr, 1'b0);
        check_val("reset_running", running, 1'b0);
        check_val("reset_running1", running1, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press: RUN at k+5, ten ticks from k+15 spaced by 10
        k = edge_cnt + 1;
        btn_run = 1'b1;
        expect_evt(2, k + 5, 1);
        for (int i = 0; i < 10; i++) expect_evt(0, k + 15 + 10 * i, 1);
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        while (edge_cnt < k + 109) @(negedge clk);

        // Bouncy stop press: 3 high, 2 low, then held; toggle 5 edges after final rise
        k2 = edge_cnt + 1;
        expect_evt(0, k + 115, 1);
        expect_evt(2, k2 + 10, 0);
        btn_run = 1'b1;
        repeat (3) @(negedge clk);
        btn_run = 1'b0;
        repeat (2) @(negedge clk);
        btn_run = 1'b1;
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        repeat (60) @(negedge clk);

        // Restart, then a clear landing on the wrap edge k3+35
        k3 = edge_cnt + 1;
        btn_run = 1'b1;
        expect_evt(2, k3 + 5, 1);
        expect_evt(0, k3 + 15, 1);
        expect_evt(0, k3 + 25, 1);
        expect_evt(1, k3 + 35, 1);
        expect_evt(0, k3 + 45, 1);
        expect_evt(0, k3 + 55, 1);
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        while (edge_cnt < k3 + 29) @(negedge clk);
        btn_clr = 1'b1;
        repeat (8) @(negedge clk);
        btn_clr = 1'b0;
        while (edge_cnt < k3 + 57) @(negedge clk);
        k4 = edge_cnt + 1;
        btn_run = 1'b1;
        expect_evt(2, k4 + 5, 0);
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        repeat (20) @(negedge clk);

        // Both buttons together from STOP
        k5 = edge_cnt + 1;
        btn_run = 1'b1;
        btn_clr = 1'b1;
        expect_evt(1, k5 + 5, 1);
        expect_evt(2, k5 + 5, 1);
        expect_evt(0, k5 + 15, 1);
        expect_evt(0, k5 + 25, 1);
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        while (edge_cnt < k5 + 28) @(negedge clk);

        // Asynchronous reset between edges while running
        #2 reset = 1'b0;
        #1;
        check_val("async_reset_enable", enable, 1'b0);
        check_val("async_reset_clr", clr, 1'b0);
        check_val("async_reset_running", running, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // PRESCALE=1 instance: enable every edge from entry+1 until the stop edge
        k6 = edge_cnt + 1;
        btn1_run = 1'b1;
        expect_evt(4, k6 + 5, 1);
        for (int e = k6 + 6; e <= k6 + 24; e++) expect_evt(3, e, 1);
        repeat (8) @(negedge clk);
        btn1_run = 1'b0;
        while (edge_cnt < k6 + 19) @(negedge clk);
        k7 = edge_cnt + 1;
        btn1_run = 1'b1;
        expect_evt(4, k7 + 5, 0);
        repeat (8) @(negedge clk);
        btn1_run = 1'b0;
        repeat (15) @(negedge clk);

        for (int ch = 0; ch < 6; ch++) begin
            checks++;
            if (exp_q[ch].size() != 0) begin
                errors++;
                $display("FAIL %s leftover: got %0d pending events, required 0",
                         chan_name[ch], exp_q[ch].size());
            end
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
